// File: rtl/usr_pkg.sv
// Shared encodings for the shift-register family: serial direction, receiver states
// and the universal_shift_register select codes.
package usr_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bus: serial input side plus valid/ready word output.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH+1)
);
  logic             sin;
  logic             sin_valid;
  logic             lsb_first;
  logic             abort;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic             overrun;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output sin, sin_valid, lsb_first, abort, pout_ready,
    input  pout, pout_valid, overrun, bit_cnt
  );

  modport slave (
    input  sin, sin_valid, lsb_first, abort, pout_ready,
    output pout, pout_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/sipo_shift_core.sv
// Bidirectional shift register with bit counter; flags the edge that completes a word.
module sipo_shift_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  input  logic             sin,
  input  logic             abort,
  output logic [WIDTH-1:0] shreg_nxt,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             last
);

  logic [WIDTH-1:0] shreg;

  // shreg_nxt includes the bit being accepted, so it is the finished word on the last edge
  always_comb begin
    shreg_nxt = {shreg[WIDTH-2:0], sin};
    if (dir == DIR_LSB) shreg_nxt = {sin, shreg[WIDTH-1:1]};
  end

  assign last = en & ~abort & (bit_cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (clr || abort) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      shreg   <= shreg_nxt;
      bit_cnt <= last ? '0 : bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial word receiver: direction latch, IDLE/COLLECT FSM, one-word output buffer and overrun flag.
//   state      | meaning
//   ST_IDLE    | no bits of a word collected, next accepted bit latches direction
//   ST_COLLECT | 1..WIDTH-1 bits collected, direction frozen until word ends
module sipo_deserializer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input logic                clk,
  input logic                clr,
  sipo_deserializer_if.slave bus
);

  state_t           state, state_nxt;
  logic             dir_q, dir_eff;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] bit_cnt;
  logic             last;
  logic [WIDTH-1:0] pout_q;
  logic             pout_valid_q;
  logic             overrun_q;

  // the first bit of a word already uses the live lsb_first value
  assign dir_eff = (state == ST_IDLE) ? bus.lsb_first : dir_q;

  sipo_shift_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .clr       (clr),
    .en        (bus.sin_valid),
    .dir       (dir_eff),
    .sin       (bus.sin),
    .abort     (bus.abort),
    .shreg_nxt (word),
    .bit_cnt   (bit_cnt),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = ST_IDLE;
    end else if (bus.sin_valid) begin
      case (state)
        ST_IDLE:    state_nxt = ST_COLLECT;
        ST_COLLECT: if (last) state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      dir_q <= DIR_MSB;
    end else if (state == ST_IDLE && bus.sin_valid && !bus.abort) begin
      dir_q <= bus.lsb_first;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (last) begin
      // a completion refills the buffer only if it is empty or being consumed now
      if (!pout_valid_q || bus.pout_ready) begin
        pout_q       <= word;
        pout_valid_q <= 1'b1;
      end else begin
        overrun_q    <= 1'b1;
      end
    end else if (pout_valid_q && bus.pout_ready) begin
      pout_valid_q <= 1'b0;
    end
  end

  assign bus.pout       = pout_q;
  assign bus.pout_valid = pout_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.bit_cnt    = bit_cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer (WIDTH=4): directed scenarios plus random traffic against a bit-queue model.
module tb_sipo_deserializer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic clr;
  int   errors = 0;
  int   checks = 0;

  sipo_deserializer_if #(.WIDTH(W)) bus ();

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model: bits of the current word in arrival order
  bit         m_bits[$];
  logic       m_dir;
  logic [W-1:0] m_pout;
  logic       m_valid;
  logic       m_ovr;

  task automatic step(input logic s, input logic sv, input logic lsb,
                      input logic ab, input logic rdy, input logic c);
    logic [W-1:0] w;
    logic         done;
    @(negedge clk);
    clr = c; bus.sin = s; bus.sin_valid = sv; bus.lsb_first = lsb;
    bus.abort = ab; bus.pout_ready = rdy;
    @(posedge clk);
    done = 1'b0;
    w = '0;
    if (c) begin
      m_bits.delete(); m_dir = 1'b0; m_pout = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      if (ab) begin
        m_bits.delete();
      end else if (sv) begin
        if (m_bits.size() == 0) m_dir = lsb;
        m_bits.push_back(s);
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            if (m_dir) w[i] = m_bits[i];
            else       w[W-1-i] = m_bits[i];
          end
          m_bits.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!m_valid || rdy) begin m_pout = w; m_valid = 1'b1; end
        else m_ovr = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  // seq[W-1] is sent first, so "1,0,1,1" is written 4'b1011
  task automatic send(input logic [W-1:0] seq, input logic lsb, input logic rdy);
    for (int i = W-1; i >= 0; i--) step(seq[i], 1'b1, lsb, 1'b0, rdy, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({bus.pout, bus.pout_valid, bus.overrun, bus.bit_cnt} !== '0) begin
      errors++;
      $display("FAIL reset: pout=%b valid=%b ovr=%b cnt=%0d, want all 0",
               bus.pout, bus.pout_valid, bus.overrun, bus.bit_cnt);
    end
  endtask

  task automatic test_msb_word();
    test_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.pout_valid !== 1'b0 || bus.bit_cnt !== 3) begin
      errors++;
      $display("FAIL msb_partial: valid=%b cnt=%0d, want 0/3", bus.pout_valid, bus.bit_cnt);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.pout !== 4'b1011 || bus.pout_valid !== 1'b1 || bus.bit_cnt !== 0) begin
      errors++;
      $display("FAIL msb_word: pout=%b valid=%b cnt=%0d, want 1011/1/0",
               bus.pout, bus.pout_valid, bus.bit_cnt);
    end
  endtask

  task automatic test_lsb_gaps();
    logic [W-1:0] seq;
    test_reset();
    seq = 4'b1101;
    for (int i = W-1; i >= 0; i--) begin
      step(seq[i], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i > 0) begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.bit_cnt !== W-i) begin
          errors++;
          $display("FAIL lsb_gap_hold: cnt=%0d, want %0d", bus.bit_cnt, W-i);
        end
      end
    end
    checks++;
    if (bus.pout !== 4'b1011 || bus.pout_valid !== 1'b1) begin
      errors++;
      $display("FAIL lsb_word: pout=%b valid=%b, want 1011/1", bus.pout, bus.pout_valid);
    end
  endtask

  task automatic test_overrun();
    test_reset();
    send(4'b1011, 1'b0, 1'b0);
    send(4'b0110, 1'b0, 1'b0);
    checks++;
    if (bus.pout !== 4'b1011 || bus.pout_valid !== 1'b1 || bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: pout=%b valid=%b ovr=%b, want 1011/1/1",
               bus.pout, bus.pout_valid, bus.overrun);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.pout_valid !== 1'b0 || bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: valid=%b ovr=%b, want 0/1", bus.pout_valid, bus.overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    test_reset();
    seq = 8'b1011_0110;
    for (int i = 7; i >= 0; i--) begin
      step(seq[i], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      if (i == 4) begin
        checks++;
        if (bus.pout !== 4'b1011 || bus.pout_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_word1: pout=%b valid=%b, want 1011/1", bus.pout, bus.pout_valid);
        end
      end else if (i == 3) begin
        checks++;
        if (bus.pout_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_consumed: valid=%b, want 0", bus.pout_valid);
        end
      end
    end
    checks++;
    if (bus.pout !== 4'b0110 || bus.pout_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_word2: pout=%b valid=%b ovr=%b, want 0110/1/0",
               bus.pout, bus.pout_valid, bus.overrun);
    end
  endtask

  task automatic test_abort_clr();
    test_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.bit_cnt !== 0 || bus.pout_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_clears: cnt=%0d valid=%b, want 0/0", bus.bit_cnt, bus.pout_valid);
    end
    send(4'b0111, 1'b0, 1'b0);
    checks++;
    if (bus.pout !== 4'b0111 || bus.pout_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_word: pout=%b valid=%b, want 0111/1", bus.pout, bus.pout_valid);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({bus.pout, bus.pout_valid, bus.overrun, bus.bit_cnt} !== '0) begin
      errors++;
      $display("FAIL clr_midword: pout=%b valid=%b ovr=%b cnt=%0d, want all 0",
               bus.pout, bus.pout_valid, bus.overrun, bus.bit_cnt);
    end
    send(4'b0111, 1'b0, 1'b0);
    checks++;
    if (bus.pout !== 4'b0111 || bus.pout_valid !== 1'b1) begin
      errors++;
      $display("FAIL clr_word: pout=%b valid=%b, want 0111/1", bus.pout, bus.pout_valid);
    end
  endtask

  task automatic test_dir_toggle();
    test_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.pout !== 4'b1011) begin
      errors++;
      $display("FAIL dir_frozen: pout=%b, want 1011", bus.pout);
    end
    send(4'b1000, 1'b1, 1'b1);
    checks++;
    if (bus.pout !== 4'b0001 || bus.pout_valid !== 1'b1) begin
      errors++;
      $display("FAIL dir_next_word: pout=%b valid=%b, want 0001/1", bus.pout, bus.pout_valid);
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom), ($urandom_range(9) < 6), 1'($urandom),
           ($urandom_range(39) == 0), ($urandom_range(3) != 0), ($urandom_range(149) == 0));
      checks++;
      if (bus.pout !== m_pout || bus.pout_valid !== m_valid ||
          bus.overrun !== m_ovr || bus.bit_cnt !== m_bits.size()) begin
        errors++;
        $display("FAIL random[%0d]: got pout=%b v=%b ovr=%b cnt=%0d, want pout=%b v=%b ovr=%b cnt=%0d",
                 n, bus.pout, bus.pout_valid, bus.overrun, bus.bit_cnt,
                 m_pout, m_valid, m_ovr, m_bits.size());
      end
    end
  endtask

  initial begin
    clr = 1'b1; bus.sin = 1'b0; bus.sin_valid = 1'b0; bus.lsb_first = 1'b0;
    bus.abort = 1'b0; bus.pout_ready = 1'b0;
    m_dir = 1'b0; m_pout = '0; m_valid = 1'b0; m_ovr = 1'b0;
    test_reset();
    test_msb_word();
    test_lsb_gaps();
    test_overrun();
    test_back_to_back();
    test_abort_clr();
    test_dir_toggle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
